// File: rtl/clk_monitor.sv
// Slow-clock activity monitor: synchronizes clk_in, emits edge pulses,
// measures rise-to-rise period and flags loss of activity.
module clk_monitor #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 100_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_in,
  input  logic             en,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] period,
  output logic             period_stb,
  output logic             period_valid,
  output logic             lost
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOST    = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic             s1_q, s2_q, s3_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             stb_q, stb_d;
  logic             valid_q, valid_d;
  logic             lost_q, lost_d;

  logic             rise_det;
  logic             fall_det;
  logic             cnt_end;
  logic [CNT_W-1:0] cnt_inc;

  assign rise_det = s2_q & ~s3_q;
  assign fall_det = ~s2_q & s3_q;
  assign cnt_end  = (cnt_q == TO_LAST);
  assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + ONE;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    stb_d    = 1'b0;
    valid_d  = valid_q;
    lost_d   = lost_q;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      valid_d = 1'b0;
      lost_d  = 1'b0;
    end else begin
      rise_d = rise_det;
      fall_d = fall_det;
      unique case (state_q)
        IDLE: begin
          if (rise_det) begin
            state_d = MEASURE;
            cnt_d   = '0;
          end else if (cnt_end) begin
            state_d = LOST;
            cnt_d   = '0;
            lost_d  = 1'b1;
            valid_d = 1'b0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        MEASURE: begin
          if (rise_det) begin
            period_d = cnt_q + ONE;
            stb_d    = 1'b1;
            valid_d  = 1'b1;
            cnt_d    = '0;
          end else if (cnt_end) begin
            state_d = LOST;
            cnt_d   = '0;
            lost_d  = 1'b1;
            valid_d = 1'b0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        LOST: begin
          cnt_d = '0;
          // first interval after a loss is discarded
          if (rise_det) begin
            state_d = MEASURE;
            lost_d  = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      stb_q    <= 1'b0;
      valid_q  <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      s1_q     <= clk_in;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      stb_q    <= stb_d;
      valid_q  <= valid_d;
      lost_q   <= lost_d;
    end
  end

  assign rise_pulse   = rise_q;
  assign fall_pulse   = fall_q;
  assign period       = period_q;
  assign period_stb   = stb_q;
  assign period_valid = valid_q;
  assign lost         = lost_q;

endmodule

// File: doc/clk_monitor.md
# clk_monitor

Clock-activity monitor running in the fast `clk` domain. It samples a slow, divided or external clock `clk_in` through a synchronizer, emits one-cycle rise and fall pulses, and measures the rise-to-rise period in `clk` cycles. It flags loss of activity after a programmable timeout. It sits downstream of the clock-divider outputs and checks that a slow timebase is alive and at the expected rate.

## Interface
- `CNT_W`, default 32: width of the period counter and `period` output.
- `TIMEOUT`, default 100_000_000: number of `clk` cycles without a detected rise before `lost` asserts. Must satisfy 2 ≤ TIMEOUT ≤ 2^CNT_W − 1.

- `clk`, in, 1: system clock. All logic is on the posedge.
- `rst`, in, 1: reset, asynchronous, active-high. Clears every register, including the synchronizer.
- `clk_in`, in, 1: monitored slow clock, asynchronous to `clk`.
- `en`, in, 1: monitor enable, synchronous to `clk`.
- `rise_pulse`, out, 1: one-cycle pulse per detected rising edge of `clk_in` while `en`=1.
- `fall_pulse`, out, 1: one-cycle pulse per detected falling edge of `clk_in` while `en`=1.
- `period`, out, CNT_W: last measured rise-to-rise period in `clk` cycles.
- `period_stb`, out, 1: one-cycle strobe when `period` is updated.
- `period_valid`, out, 1: `period` holds a measurement from the current uninterrupted run.
- `lost`, out, 1: no rise seen for TIMEOUT cycles.

## Operation
- **Synchronizer:** `s1 <= clk_in`, `s2 <= s1`, `s3 <= s2`.
  - Internal `rise_det = s2 & ~s3`.
  - Internal `fall_det = ~s2 & s3`.
- **States:** IDLE, MEASURE, LOST. Reset state is IDLE.
- **Counter `cnt`:**
  - Increments every cycle in IDLE and MEASURE and saturates at all-ones.
  - Set to 0 on every rise event.
  - Held at 0 in LOST and whenever `en`=0.
- **IDLE:**
  - `rise_det` moves to MEASURE with `cnt`=0. No period update.
  - `cnt` = TIMEOUT−1 with no rise moves to LOST.
- **MEASURE:**
  - `rise_det` registers `period <= cnt+1`, pulses `period_stb`, sets `period_valid`=1, sets `cnt`=0, and stays in MEASURE.
  - `cnt` = TIMEOUT−1 with no rise moves to LOST, with `lost`=1 and `period_valid`=0.
- **LOST:**
  - `rise_det` moves to MEASURE, clears `lost`, and sets `cnt`=0. No period update, because the first interval after a loss is discarded.
- **`en`=0:**
  - State forced to IDLE, `cnt`=0, `period_valid`=0, `lost`=0.
  - `period` holds its last value.
  - `rise_pulse` and `fall_pulse` are suppressed.
  - The synchronizer keeps running.
- **Simultaneous events:**
  - `rise_det` and `cnt` = TIMEOUT−1 in the same cycle: the rise wins. In MEASURE the period updates to TIMEOUT and no loss is flagged.
  - `en` falling and `rise_det` in the same cycle: `en` wins. No pulses and no update.
- **Width:** `cnt+1` is computed in CNT_W bits. Saturation prevents wrap, but saturation is unreachable while TIMEOUT fits in CNT_W.

## Timing
- **Reset values:** `rise_pulse`, `fall_pulse`, `period_stb`, `period_valid`, `lost` = 0. `period` = 0. `s1`, `s2`, `s3` = 0. State = IDLE.
- **Output registration:** all outputs are registered.
- **Edge latency:** `clk_in` rises before posedge N. Then:
  - `rise_det` is high between N+1 and N+2.
  - `rise_pulse` and `period_stb` are high for exactly one cycle, from N+2 to N+3.
  - `period` and `period_valid` change at N+2.
- **`lost` timing:** asserts at the edge where the state enters LOST, i.e. TIMEOUT cycles after the last rise event, and deasserts together with the next `rise_pulse`.
- **Measurement accuracy:** for a steady `clk_in` of P cycles, `period` = P exactly. Synchronizer jitter is at most ±1 cycle for asynchronous inputs.
- **Pulse widths:** `clk_in` high and low phases must each last ≥2 `clk` cycles to be detected.
- **Reset mid-operation:** takes effect immediately (asynchronous). The first `rise_pulse` after release requires a fresh low-to-high transition of `clk_in` as sampled by the synchronizer.

## Test plan
All scenarios use TIMEOUT=20 and CNT_W=16.

- **Steady clock:** `clk_in` = 4 high / 4 low, `en`=1 after reset.
  - First rise gives `rise_pulse` with no `period_stb`.
  - Each later rise gives `period_stb` with `period`=8 and `period_valid`=1.
  - `fall_pulse` occurs 4 cycles after each `rise_pulse`.
- **Loss:** hold `clk_in` high after a rise.
  - `lost`=1 and `period_valid`=0 exactly 20 cycles after that rise event.
  - No further pulses.
- **Recovery:** resume 6/6 toggling after loss.
  - First rise clears `lost` with no strobe.
  - Next rise gives `period`=12 and `period_valid`=1.
- **Boundary:** `clk_in` period exactly 20 (10/10).
  - No `lost`.
  - `period`=20 on every strobe.
- **Enable:** drop `en` mid-run with `period`=8.
  - `period_valid`=0 and `lost`=0, with no pulses even while `clk_in` toggles.
  - `period` stays 8.
  - Re-enable: the first rise does not strobe, and the second gives 8.
- **Reset:** assert `rst` for 1 cycle during MEASURE.
  - All outputs return to 0 immediately.
  - The measurement restarts as in the steady-clock scenario.
